stream_frame_source: RTL and testbench
======================================

# stream_frame_source

Synthesisable, parametrised stream stimulus source for the Img2Col and systolic-array datapath, used both in simulation and on the board. It plays a preloaded frame buffer into a DUT through a valid/ready master port under a programmable burst/gap duty cycle. It sinks the DUT's result stream, counts result beats per frame and re-launches the next frame automatically on the DUT's last beat. An optional scale/bias table with one-cycle read latency supplies the quantisation constants the DUT fetches.

## Interface
- DATA_WIDTH, 64, frame-buffer word and m_data width
- MEM_DEPTH, 50176, frame-buffer words (224*224)
- ADDR_WIDTH, 16, frame-buffer address width, ≥ clog2(MEM_DEPTH)
- CNT_WIDTH, 32, beat counters and total_beats width
- PHASE_WIDTH, 10, throttle phase counter width
- SB_DEPTH, 384, scale/bias entries
- SB_ADDR_WIDTH, 9, scale/bias address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle launch pulse, honoured only in IDLE
- restart_en  in  1  relaunch after each frame; sampled at every frame end
- total_beats  in  CNT_WIDTH  input beats per frame; sampled at launch; 0 = frame of zero input beats
- period_len  in  PHASE_WIDTH  throttle period in cycles; sampled at launch; 0 treated as 1
- burst_len  in  PHASE_WIDTH  cycles per period in which new m_valid may assert; sampled at launch
- ld_en  in  1  frame-buffer write strobe, ignored unless IDLE
- ld_addr  in  ADDR_WIDTH  frame-buffer write address
- ld_data  in  DATA_WIDTH  frame-buffer write data
- m_valid  out  1  beat valid to DUT
- m_ready  in  1  DUT ready
- m_data  out  DATA_WIDTH  frame-buffer word at rd_addr
- frame_start  out  1  one-cycle start pulse to DUT
- s_valid  in  1  DUT result valid
- s_ready  out  1  result ready
- s_last  in  1  last result beat of frame
- out_count  out  CNT_WIDTH  results accepted in current frame
- last_frame_count  out  CNT_WIDTH  out_count captured at last frame end
- frame_cnt  out  CNT_WIDTH  completed frames since launch
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when returning to IDLE
- sb_ld_en, sb_ld_addr[SB_ADDR_WIDTH], sb_ld_data[16]  in  table write, {scale[15:8], bias[7:0]}
- scale_addr, bias_addr  in  SB_ADDR_WIDTH  table read addresses
- scale_out, bias_out  out  8  registered table reads

## Operation
- States: IDLE, LAUNCH, RUN, DRAIN.
- IDLE + start → LAUNCH. LAUNCH lasts 1 cycle: frame_start=1, rd_addr, in_cnt, phase, out_count cleared; → RUN.
- RUN: phase counts 0..period_len−1 and wraps. m_valid rises when phase<burst_len and in_cnt<total_beats. Once high, m_valid holds until m_valid&m_ready, regardless of phase.
- Each handshake: in_cnt+1; rd_addr+1, wrapping MEM_DEPTH−1→0. When in_cnt reaches total_beats → DRAIN.
- s_ready=1 in RUN and DRAIN, 0 in IDLE/LAUNCH. Each s_valid&s_ready increments out_count.
- Frame end = s_valid&s_ready&s_last, from RUN or DRAIN: last_frame_count←out_count+1, out_count←0, frame_cnt+1, m_valid dropped.
  - restart_en=1 → LAUNCH.
  - restart_en=0 → IDLE with done=1.
- s_last in RUN aborts remaining input beats.
- start outside IDLE is ignored. ld_en outside IDLE is ignored.
- Counters wrap modulo 2^CNT_WIDTH; no saturation.

## Timing
- Reset values: m_valid, frame_start, s_ready, busy, done, scale_out, bias_out = 0; all counters = 0; state IDLE.
- start@T → frame_start@T+1 → first possible m_valid@T+2. m_valid is a register.
- m_data is combinational from rd_addr and is valid the same cycle as m_valid.
- Frame end@E → with restart_en, frame_start@E+1.
- scale_out/bias_out = table[addr] one cycle after the address is presented.
- Reset deassertion mid-frame is not supported. Reset assertion returns to IDLE immediately. Frame-buffer and table contents are not cleared.

## Configuration
- STREAM_SRC_SCALE_BIAS_EN defined: SB_DEPTH×16 table, load port and registered reads are built.
- Undefined: no table storage; scale_out=bias_out=0 constantly; sb_* inputs unused.

## Test plan
- Load words 0..7 = k; total_beats=8, period=4, burst=2, m_ready=1 → m_valid high 2 of every 4 cycles, m_data 0..7, → DRAIN after 8th beat.
- m_ready held 0 for 5 cycles mid-burst → m_valid and m_data stable, no beat lost, in_cnt unchanged.
- MEM_DEPTH=4, total_beats=10 → m_data sequence 0,1,2,3,0,1,2,3,0,1.
- DUT returns 3 results with s_last on 3rd, restart_en=1 → last_frame_count=3, frame_start 1 cycle later, rd_addr restarts at 0, frame_cnt=1.
- restart_en=0 at frame end → done pulse; busy=0; a later start relaunches.
- With macro: load entry 5 = 16'hA37F, scale_addr=bias_addr=5 → scale_out=8'hA3, bias_out=8'h7F next cycle. Without macro → both 0.

Source files
------------

// File: rtl/stream_frame_source.sv
// Frame-buffer stimulus player with burst/gap throttle, result sink and automatic relaunch.
// Optional scale/bias table is built when STREAM_SRC_SCALE_BIAS_EN is defined.
module stream_frame_source #(
    parameter int DATA_WIDTH    = 64,
    parameter int MEM_DEPTH     = 50176,
    parameter int ADDR_WIDTH    = 16,
    parameter int CNT_WIDTH     = 32,
    parameter int PHASE_WIDTH   = 10,
    parameter int SB_DEPTH      = 384,
    parameter int SB_ADDR_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     restart_en,
    input  logic [CNT_WIDTH-1:0]     total_beats,
    input  logic [PHASE_WIDTH-1:0]   period_len,
    input  logic [PHASE_WIDTH-1:0]   burst_len,
    input  logic                     ld_en,
    input  logic [ADDR_WIDTH-1:0]    ld_addr,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     frame_start,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_last,
    output logic [CNT_WIDTH-1:0]     out_count,
    output logic [CNT_WIDTH-1:0]     last_frame_count,
    output logic [CNT_WIDTH-1:0]     frame_cnt,
    output logic                     busy,
    output logic                     done,
    input  logic                     sb_ld_en,
    input  logic [SB_ADDR_WIDTH-1:0] sb_ld_addr,
    input  logic [15:0]              sb_ld_data,
    input  logic [SB_ADDR_WIDTH-1:0] scale_addr,
    input  logic [SB_ADDR_WIDTH-1:0] bias_addr,
    output logic [7:0]               scale_out,
    output logic [7:0]               bias_out
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]  ADDR_LAST  = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ZERO  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   CNT_ZERO   = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [PHASE_WIDTH-1:0] PHASE_ZERO = PHASE_WIDTH'(0);
    localparam logic [PHASE_WIDTH-1:0] PHASE_ONE  = PHASE_WIDTH'(1);

    state_t                  r_state, w_state_next;
    logic [CNT_WIDTH-1:0]    r_total, r_in_cnt, w_in_cnt_next;
    logic [PHASE_WIDTH-1:0]  r_period, r_burst, r_phase, w_phase_next, w_phase_wrap;
    logic [ADDR_WIDTH-1:0]   r_rd_addr, w_rd_addr_next;
    logic [CNT_WIDTH-1:0]    r_out_count, w_out_count_next;
    logic [CNT_WIDTH-1:0]    r_last_frame_count, r_frame_cnt, w_frame_cnt_next;
    logic                    r_m_valid, w_m_valid_next;
    logic                    r_frame_start, r_s_ready, r_busy, r_done;
    logic                    w_hs, w_s_fire, w_frame_end, w_launch;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    // Next-state, beat counters and throttle decision
    always_comb begin
        w_hs             = r_m_valid & m_ready;
        w_s_fire         = s_valid & r_s_ready;
        w_frame_end      = w_s_fire & s_last;
        w_phase_wrap     = (r_phase >= r_period - PHASE_ONE) ? PHASE_ZERO : r_phase + PHASE_ONE;
        w_state_next     = r_state;
        w_in_cnt_next    = r_in_cnt;
        w_rd_addr_next   = r_rd_addr;
        w_phase_next     = r_phase;
        w_m_valid_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_LAUNCH;
                else       w_state_next = ST_IDLE;
            end
            ST_LAUNCH: begin
                w_state_next   = ST_RUN;
                w_in_cnt_next  = CNT_ZERO;
                w_rd_addr_next = ADDR_ZERO;
                w_phase_next   = PHASE_ZERO;
                w_m_valid_next = (r_burst != PHASE_ZERO) && (r_total != CNT_ZERO);
            end
            ST_RUN: begin
                w_phase_next = w_phase_wrap;
                if (w_hs) begin
                    w_in_cnt_next  = r_in_cnt + CNT_ONE;
                    w_rd_addr_next = (r_rd_addr == ADDR_LAST) ? ADDR_ZERO : r_rd_addr + ADDR_ONE;
                end else begin
                    w_in_cnt_next  = r_in_cnt;
                    w_rd_addr_next = r_rd_addr;
                end
                // A pending beat is held regardless of phase; new beats only inside the burst window
                if (w_frame_end)                   w_state_next = restart_en ? ST_LAUNCH : ST_IDLE;
                else if (w_in_cnt_next == r_total) w_state_next = ST_DRAIN;
                else w_m_valid_next = (r_m_valid & ~m_ready) | (w_phase_next < r_burst);
            end
            ST_DRAIN: begin
                if (w_frame_end) w_state_next = restart_en ? ST_LAUNCH : ST_IDLE;
                else             w_state_next = ST_DRAIN;
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (r_state == ST_LAUNCH) w_out_count_next = CNT_ZERO;
        else if (w_frame_end)     w_out_count_next = CNT_ZERO;
        else if (w_s_fire)        w_out_count_next = r_out_count + CNT_ONE;
        else                      w_out_count_next = r_out_count;

        if ((r_state == ST_IDLE) && start) w_frame_cnt_next = CNT_ZERO;
        else if (w_frame_end)              w_frame_cnt_next = r_frame_cnt + CNT_ONE;
        else                               w_frame_cnt_next = r_frame_cnt;

        w_launch = (w_state_next == ST_LAUNCH);
    end

    // Control state, counters and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= ST_IDLE;
            r_total            <= CNT_ZERO;
            r_period           <= PHASE_ONE;
            r_burst            <= PHASE_ZERO;
            r_in_cnt           <= CNT_ZERO;
            r_phase            <= PHASE_ZERO;
            r_rd_addr          <= ADDR_ZERO;
            r_out_count        <= CNT_ZERO;
            r_last_frame_count <= CNT_ZERO;
            r_frame_cnt        <= CNT_ZERO;
            r_m_valid          <= 1'b0;
            r_frame_start      <= 1'b0;
            r_s_ready          <= 1'b0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_in_cnt      <= w_in_cnt_next;
            r_phase       <= w_phase_next;
            r_rd_addr     <= w_rd_addr_next;
            r_out_count   <= w_out_count_next;
            r_frame_cnt   <= w_frame_cnt_next;
            r_m_valid     <= w_m_valid_next;
            r_frame_start <= w_launch;
            r_s_ready     <= (w_state_next == ST_RUN) || (w_state_next == ST_DRAIN);
            r_busy        <= (w_state_next != ST_IDLE);
            r_done        <= w_frame_end & ~restart_en;
            if (w_frame_end) r_last_frame_count <= r_out_count + CNT_ONE;
            if (w_launch) begin
                r_total  <= total_beats;
                r_period <= (period_len == PHASE_ZERO) ? PHASE_ONE : period_len;
                r_burst  <= burst_len;
            end
        end
    end

    // Frame-buffer load port, only open while idle
    always_ff @(posedge clk) begin
        if (ld_en && (r_state == ST_IDLE) && (32'(ld_addr) < MEM_DEPTH)) r_mem[ld_addr] <= ld_data;
    end

    assign m_data           = r_mem[r_rd_addr];
    assign m_valid          = r_m_valid;
    assign frame_start      = r_frame_start;
    assign s_ready          = r_s_ready;
    assign out_count        = r_out_count;
    assign last_frame_count = r_last_frame_count;
    assign frame_cnt        = r_frame_cnt;
    assign busy             = r_busy;
    assign done             = r_done;

`ifdef STREAM_SRC_SCALE_BIAS_EN
    logic [15:0] r_sb_mem [SB_DEPTH];
    logic [7:0]  r_scale_out, r_bias_out;

    // Scale/bias table load port
    always_ff @(posedge clk) begin
        if (sb_ld_en && (32'(sb_ld_addr) < SB_DEPTH)) r_sb_mem[sb_ld_addr] <= sb_ld_data;
    end

    // One-cycle-latency table reads; out-of-range addresses read as zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scale_out <= 8'd0;
            r_bias_out  <= 8'd0;
        end else begin
            r_scale_out <= (32'(scale_addr) < SB_DEPTH) ? r_sb_mem[scale_addr][15:8] : 8'd0;
            r_bias_out  <= (32'(bias_addr)  < SB_DEPTH) ? r_sb_mem[bias_addr][7:0]   : 8'd0;
        end
    end

    assign scale_out = r_scale_out;
    assign bias_out  = r_bias_out;
`else
    logic w_sb_unused;
    assign w_sb_unused = ^{sb_ld_en, sb_ld_addr, sb_ld_data, scale_addr, bias_addr, 32'(SB_DEPTH)};
    assign scale_out   = 8'd0;
    assign bias_out    = 8'd0;
`endif
endmodule

// File: tb/tb_stream_frame_source.sv
// Directed self-checking bench for stream_frame_source: throttle, stall, address wrap,
// result sinking with relaunch/done, ignored start/load, abort and scale/bias reads.
module tb_stream_frame_source;
    localparam int DW  = 64;
    localparam int CW  = 32;
    localparam int PW  = 10;
    localparam int SAW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, restart_en, ld_en, m_ready, s_valid, s_last, sb_ld_en;
    logic [CW-1:0]  total_beats;
    logic [PW-1:0]  period_len, burst_len;
    logic [3:0]     ld_addr;
    logic [DW-1:0]  ld_data;
    logic [SAW-1:0] sb_ld_addr, scale_addr, bias_addr;
    logic [15:0]    sb_ld_data;
    logic           m_valid, frame_start, s_ready, busy, done;
    logic [DW-1:0]  m_data;
    logic [CW-1:0]  out_count, last_frame_count, frame_cnt;
    logic [7:0]     scale_out, bias_out;

    logic           start4, ld_en4;
    logic           m_valid4, frame_start4, s_ready4, busy4, done4;
    logic [DW-1:0]  m_data4;
    logic [CW-1:0]  out_count4, last_frame_count4, frame_cnt4;
    logic [7:0]     scale_out4, bias_out4;

    int n_checks = 0;
    int n_errors = 0;

    stream_frame_source #(.MEM_DEPTH(16), .ADDR_WIDTH(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .restart_en(restart_en),
        .total_beats(total_beats), .period_len(period_len), .burst_len(burst_len),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .frame_start(frame_start),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .out_count(out_count), .last_frame_count(last_frame_count), .frame_cnt(frame_cnt),
        .busy(busy), .done(done),
        .sb_ld_en(sb_ld_en), .sb_ld_addr(sb_ld_addr), .sb_ld_data(sb_ld_data),
        .scale_addr(scale_addr), .bias_addr(bias_addr), .scale_out(scale_out), .bias_out(bias_out)
    );

    stream_frame_source #(.MEM_DEPTH(4), .ADDR_WIDTH(2)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .restart_en(1'b0),
        .total_beats(32'd10), .period_len(10'd1), .burst_len(10'd1),
        .ld_en(ld_en4), .ld_addr(ld_addr[1:0]), .ld_data(ld_data),
        .m_valid(m_valid4), .m_ready(1'b1), .m_data(m_data4), .frame_start(frame_start4),
        .s_valid(1'b0), .s_ready(s_ready4), .s_last(1'b0),
        .out_count(out_count4), .last_frame_count(last_frame_count4), .frame_cnt(frame_cnt4),
        .busy(busy4), .done(done4),
        .sb_ld_en(1'b0), .sb_ld_addr(9'd0), .sb_ld_data(16'd0),
        .scale_addr(9'd0), .bias_addr(9'd0), .scale_out(scale_out4), .bias_out(bias_out4)
    );

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int   beat;
        logic exp_v;
        reset = 1'b0; start = 1'b0; restart_en = 1'b0; ld_en = 1'b0; m_ready = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; sb_ld_en = 1'b0; total_beats = 32'd0;
        period_len = 10'd0; burst_len = 10'd0; ld_addr = 4'd0; ld_data = 64'd0;
        sb_ld_addr = 9'd0; sb_ld_data = 16'd0; scale_addr = 9'd0; bias_addr = 9'd0;
        start4 = 1'b0; ld_en4 = 1'b0;

        repeat (3) @(negedge clk);
        check_value("rst_m_valid", m_valid, 1'b0);
        check_value("rst_frame_start", frame_start, 1'b0);
        check_value("rst_s_ready", s_ready, 1'b0);
        check_value("rst_busy", busy, 1'b0);
        check_value("rst_done", done, 1'b0);
        check_value("rst_out_count", out_count, 32'd0);
        check_value("rst_last_count", last_frame_count, 32'd0);
        check_value("rst_frame_cnt", frame_cnt, 32'd0);
        check_value("rst_scale", scale_out, 8'd0);
        check_value("rst_bias", bias_out, 8'd0);
        reset = 1'b1;
        @(negedge clk);

        // Scale/bias table
        sb_ld_en = 1'b1; sb_ld_addr = 9'd5; sb_ld_data = 16'hA37F;
        @(negedge clk);
        sb_ld_en = 1'b0; scale_addr = 9'd5; bias_addr = 9'd5;
        @(negedge clk);
`ifdef STREAM_SRC_SCALE_BIAS_EN
        check_value("sb_scale", scale_out, 8'hA3);
        check_value("sb_bias", bias_out, 8'h7F);
`else
        check_value("sb_scale_off", scale_out, 8'h00);
        check_value("sb_bias_off", bias_out, 8'h00);
`endif

        // Load buffers: word k = k
        for (int k = 0; k < 8; k++) begin
            ld_en = 1'b1; ld_addr = 4'(k); ld_data = 64'(k);
            @(negedge clk);
        end
        ld_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ld_en4 = 1'b1; ld_addr = 4'(k); ld_data = 64'(k);
            @(negedge clk);
        end
        ld_en4 = 1'b0;

        // Depth-4 wrap: 10 beats read 0,1,2,3,0,1,2,3,0,1
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check_value("wrap_frame_start", frame_start4, 1'b1);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            check_value($sformatf("wrap_valid_%0d", j), m_valid4, (j < 10));
            if (j < 10) check_value($sformatf("wrap_data_%0d", j), m_data4, 64'(j % 4));
        end

        // Frame A: 8 beats, period 4, burst 2
        total_beats = 32'd8; period_len = 10'd4; burst_len = 10'd2; m_ready = 1'b1; restart_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_value("a_frame_start", frame_start, 1'b1);
        check_value("a_busy", busy, 1'b1);
        check_value("a_launch_valid", m_valid, 1'b0);
        check_value("a_launch_s_ready", s_ready, 1'b0);
        beat = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            exp_v = ((i % 4) < 2);
            check_value($sformatf("a_valid_%0d", i), m_valid, exp_v);
            if (exp_v) begin
                check_value($sformatf("a_data_%0d", i), m_data, 64'(beat));
                beat++;
            end
        end
        check_value("a_run_frame_start", frame_start, 1'b0);
        @(negedge clk);
        check_value("a_drain_valid", m_valid, 1'b0);
        check_value("a_drain_s_ready", s_ready, 1'b1);
        check_value("a_drain_busy", busy, 1'b1);

        // Three results, s_last on the third, relaunch into frame B
        total_beats = 32'd6; period_len = 10'd0; burst_len = 10'd1;
        s_valid = 1'b1; s_last = 1'b0;
        @(negedge clk);
        check_value("a_out_count_1", out_count, 32'd1);
        @(negedge clk);
        check_value("a_out_count_2", out_count, 32'd2);
        s_last = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        check_value("a_restart_frame_start", frame_start, 1'b1);
        check_value("a_last_frame_count", last_frame_count, 32'd3);
        check_value("a_frame_cnt", frame_cnt, 32'd1);
        check_value("a_out_count_clr", out_count, 32'd0);
        check_value("a_done_on_restart", done, 1'b0);

        // Frame B: continuous valid (period 0 = 1), 5-cycle stall after 2 beats
        beat = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            exp_v = (beat < 6);
            check_value($sformatf("b_valid_%0d", j), m_valid, exp_v);
            if (exp_v) check_value($sformatf("b_data_%0d", j), m_data, 64'(beat));
            m_ready = !((j >= 3) && (j <= 7));
            if (exp_v && m_ready) beat++;
        end
        m_ready = 1'b1;

        // start and buffer load are ignored while busy
        ld_en = 1'b1; ld_addr = 4'd0; ld_data = 64'hDEAD; start = 1'b1;
        @(negedge clk);
        ld_en = 1'b0; start = 1'b0;
        check_value("b_start_ignored", frame_start, 1'b0);
        check_value("b_busy", busy, 1'b1);
        restart_en = 1'b0; s_valid = 1'b1; s_last = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        check_value("b_done", done, 1'b1);
        check_value("b_idle_busy", busy, 1'b0);
        check_value("b_idle_s_ready", s_ready, 1'b0);
        check_value("b_last_frame_count", last_frame_count, 32'd1);
        check_value("b_frame_cnt", frame_cnt, 32'd2);
        @(negedge clk);
        check_value("b_done_pulse", done, 1'b0);

        // Frame C: later start relaunches, one beat, buffer word 0 untouched
        total_beats = 32'd1; period_len = 10'd4; burst_len = 10'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_value("c_frame_start", frame_start, 1'b1);
        check_value("c_frame_cnt_clr", frame_cnt, 32'd0);
        @(negedge clk);
        check_value("c_valid", m_valid, 1'b1);
        check_value("c_data_word0", m_data, 64'd0);
        @(negedge clk);
        check_value("c_drain_valid", m_valid, 1'b0);
        s_valid = 1'b1; s_last = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        check_value("c_done", done, 1'b1);
        check_value("c_frame_cnt", frame_cnt, 32'd1);

        // Frame D: s_last in RUN aborts the remaining beats
        total_beats = 32'd8; period_len = 10'd1; burst_len = 10'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_value("d_frame_start", frame_start, 1'b1);
        @(negedge clk);
        check_value("d_valid", m_valid, 1'b1);
        s_valid = 1'b1; s_last = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        check_value("d_abort_valid", m_valid, 1'b0);
        check_value("d_abort_done", done, 1'b1);
        check_value("d_abort_busy", busy, 1'b0);
        check_value("d_last_frame_count", last_frame_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
